// File: rtl/multicycle_computer_controller_main_fsm.sv
// Main sequencing FSM of the multicycle computer controller.
// Walks each instruction through fetch/decode/execute and drives Moore-style
// datapath enables (MEM_READY also gates fetch and memory-access states).
// Counts retired instructions in INSTR_CNT (wraps modulo 2^CNT_W).
// Optional build macro: HALT_ON_UNDEF_EN -- op=11 parks the FSM in s14 (HALT)
// until reset; when undefined, op=11 retires as a NOP.
module multicycle_computer_controller_main_fsm #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      INSTRUCTION,
  input  logic [3:0]       FLAGS,
  input  logic             MEM_READY,
  output logic [3:0]       current_state,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             LinkWrite,
  output logic             FlagWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [CNT_W-1:0] INSTR_CNT
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECUTEI = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_SHIFTEX  = 4'd10;
  localparam logic [3:0] S_SHIFTWB  = 4'd11;
  localparam logic [3:0] S_CMPR     = 4'd12;
  localparam logic [3:0] S_UNUSED   = 4'd13;
  localparam logic [3:0] S_HALT     = 4'd14;
  localparam logic [3:0] S_CMPI     = 4'd15;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic       i_bit;
  logic [3:0] cmd;
  logic       s_bit;
  logic       link_bit;
  logic       cond_ok;
  logic       unused_instr_bits;

  assign cond     = INSTRUCTION[31:28];
  assign op       = INSTRUCTION[27:26];
  assign i_bit    = INSTRUCTION[25];
  assign cmd      = INSTRUCTION[24:21];
  assign s_bit    = INSTRUCTION[20];
  assign link_bit = INSTRUCTION[24];
  assign unused_instr_bits = ^INSTRUCTION[19:0];

  // Condition-code check against the NZCV flags presented this cycle
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = cf;
      4'b0011: r = !cf;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = cf && !z;
      4'b1001: r = !cf || z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z && (n == v);
      4'b1101: r = z || (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign cond_ok = cond_pass(cond, FLAGS);

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (MEM_READY) state_d = S_DECODE;
      S_DECODE: begin
        if (!cond_ok) begin
          state_d = S_FETCH;
        end else begin
          case (op)
            2'b00: begin
              if (cmd[3:2] == 2'b10)              state_d = i_bit ? S_CMPI : S_CMPR;
              else if (cmd == 4'b1101 && !i_bit)  state_d = S_SHIFTEX;
              else                                state_d = i_bit ? S_EXECUTEI : S_EXECUTER;
            end
            2'b01:   state_d = S_MEMADR;
            2'b10:   state_d = S_BRANCH;
            default: begin
`ifdef HALT_ON_UNDEF_EN
              state_d = S_HALT;
`else
              state_d = S_FETCH;
`endif
            end
          endcase
        end
      end
      S_MEMADR:   state_d = s_bit ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (MEM_READY) state_d = S_MEMWB;
      S_MEMWRITE: if (MEM_READY) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_SHIFTEX:  state_d = S_SHIFTWB;
      S_HALT: begin
`ifdef HALT_ON_UNDEF_EN
        state_d = S_HALT;
`else
        state_d = S_FETCH;
`endif
      end
      default:    state_d = S_FETCH;
    endcase
  end

  // Retire count: every entry into FETCH from another state
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != S_FETCH && state_d == S_FETCH) cnt_d = cnt_q + CNT_W'(1);
  end

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore-style datapath enables (MEM_READY gates fetch writes)
  always_comb begin
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    LinkWrite = 1'b0;
    FlagWrite = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      S_FETCH: begin
        IRWrite   = MEM_READY;
        PCWrite   = MEM_READY;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR:   ALUSrcB = 2'b01;
      S_MEMREAD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = 2'b01;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTEI: ALUSrcB = 2'b01;
      S_ALUWB, S_SHIFTWB: begin
        RegWrite  = 1'b1;
        FlagWrite = s_bit;
      end
      S_CMPR:     FlagWrite = 1'b1;
      S_CMPI: begin
        ALUSrcB   = 2'b01;
        FlagWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        LinkWrite = link_bit;
      end
      default: ;
    endcase
  end

  assign current_state = state_q;
  assign INSTR_CNT     = cnt_q;

endmodule
